// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default widths and the load-size encoding.
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_RA_W   = 5;

    // 2'b11 is not named and is handled as a word load.
    typedef enum logic [1:0] {
        LD_WORD = 2'b00,
        LD_HALF = 2'b01,
        LD_BYTE = 2'b10
    } ld_size_e;

endpackage

// File: rtl/load_align.sv
// Big-endian sub-word load extraction with sign or zero extension (DATA_W >= 32).
module load_align
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W
) (
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        offset,
    input  ld_size_e          size,
    input  logic              ld_unsigned,
    output logic [DATA_W-1:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_data[31:24];
        case (offset)
            2'd0:    byte_sel = mem_data[31:24];
            2'd1:    byte_sel = mem_data[23:16];
            2'd2:    byte_sel = mem_data[15:8];
            default: byte_sel = mem_data[7:0];
        endcase

        // offset[0] is deliberately ignored for halfwords
        half_sel = offset[1] ? mem_data[15:0] : mem_data[31:16];

        data_out = mem_data;
        case (size)
            LD_BYTE: data_out = {{(DATA_W-8){~ld_unsigned & byte_sel[7]}}, byte_sel};
            LD_HALF: data_out = {{(DATA_W-16){~ld_unsigned & half_sel[15]}}, half_sel};
            default: data_out = mem_data;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: stage register, writeback mux and retired-instruction counter.
// Sub-word load extraction is enabled by defining MEM_WB_SUBWORD_EN.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int RA_W   = MIPS_RA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic [DATA_W-1:0] mem_data,
    output logic              wb_en,
    output logic [RA_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       retired_cnt
);

    logic              valid_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic [RA_W-1:0]   rd_q;
    logic [DATA_W-1:0] alu_result_q;
    logic [31:0]       retired_q;

    // Flush only drops the valid bit; the payload fields simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= '0;
            alu_result_q <= '0;
            retired_q    <= '0;
        end else begin
            if (valid_q && !stall) begin
                retired_q <= retired_q + 32'd1;
            end
            if (flush) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q      <= in_valid;
                reg_write_q  <= in_reg_write;
                mem_to_reg_q <= in_mem_to_reg;
                rd_q         <= in_rd;
                alu_result_q <= in_alu_result;
            end
        end
    end

`ifdef MEM_WB_SUBWORD_EN
    ld_size_e          ld_size_q;
    logic              ld_unsigned_q;
    logic [DATA_W-1:0] load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_size_q     <= LD_WORD;
            ld_unsigned_q <= 1'b0;
        end else if (!flush && !stall) begin
            ld_size_q     <= ld_size_e'(in_ld_size);
            ld_unsigned_q <= in_ld_unsigned;
        end
    end

    load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .mem_data    (mem_data),
        .offset      (alu_result_q[1:0]),
        .size        (ld_size_q),
        .ld_unsigned (ld_unsigned_q),
        .data_out    (load_data)
    );

    assign wb_data = mem_to_reg_q ? load_data : alu_result_q;
`else
    logic [2:0] unused_ld;
    assign unused_ld = {in_ld_size, in_ld_unsigned};

    assign wb_data = mem_to_reg_q ? mem_data : alu_result_q;
`endif

    assign wb_en       = valid_q & reg_write_q & (rd_q != '0);
    assign wb_rd       = rd_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: per-cycle model comparison plus directed literal checks.
module tb_mem_wb_stage;

`ifdef MEM_WB_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        in_valid, in_reg_write, in_mem_to_reg;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic [31:0] mem_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] retired_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit live    = 1'b0;

    mem_wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_reg_write   (in_reg_write),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_rd          (in_rd),
        .in_alu_result  (in_alu_result),
        .in_ld_size     (in_ld_size),
        .in_ld_unsigned (in_ld_unsigned),
        .mem_data       (mem_data),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .retired_cnt    (retired_cnt)
    );

    always #5 clk = ~clk;

    // Model of the instruction currently sitting in the stage
    bit          m_valid, m_rw, m_m2r, m_uns;
    logic [4:0]  m_rd;
    logic [31:0] m_alu;
    logic [1:0]  m_sz;
    logic [31:0] m_cnt;

    function automatic logic [31:0] exp_data(input logic m2r, input logic [31:0] alu,
                                             input logic [1:0] sz, input logic u,
                                             input logic [31:0] md);
        logic [31:0] v;
        int sh;
        if (!m2r) return alu;
        if (!SUBWORD) return md;
        if (sz == 2'b10) begin
            sh = 8 * (3 - int'(alu[1:0]));
            v  = (md >> sh) & 32'h0000_00FF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (sz == 2'b01) begin
            sh = alu[1] ? 0 : 16;
            v  = (md >> sh) & 32'h0000_FFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
            return v;
        end
        return md;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 0; m_rw = 0; m_m2r = 0; m_uns = 0;
            m_rd = '0; m_alu = '0; m_sz = '0; m_cnt = '0;
        end else begin
            if (m_valid && !stall) m_cnt = m_cnt + 32'd1;
            if (flush) begin
                m_valid = 0;
            end else if (!stall) begin
                m_valid = in_valid; m_rw = in_reg_write; m_m2r = in_mem_to_reg;
                m_rd = in_rd; m_alu = in_alu_result; m_sz = in_ld_size; m_uns = in_ld_unsigned;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            check("model wb_en", {31'd0, wb_en}, {31'd0, m_valid && m_rw && (m_rd != 5'd0)});
            check("model wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
            check("model wb_data", wb_data, exp_data(m_m2r, m_alu, m_sz, m_uns, mem_data));
            check("model retired_cnt", retired_cnt, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [1:0] sz, input logic u);
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_rd = rd;
        in_alu_result = alu; in_ld_size = sz; in_ld_unsigned = u;
    endtask

    task automatic bubble();
        drive(0, 0, 0, 5'd0, 32'd0, 2'b00, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; stall = 0; flush = 0; mem_data = 32'd0;
        bubble();
        tick(); live = 1'b1;
        tick();
        check("reset wb_en", {31'd0, wb_en}, 32'd0);
        check("reset wb_rd", {27'd0, wb_rd}, 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        check("reset retired", retired_cnt, 32'd0);
        rst = 0;

        drive(1, 1, 0, 5'd8, 32'h1234_5678, 2'b00, 0);
        tick();
        check("alu wb_en", {31'd0, wb_en}, 32'd1);
        check("alu wb_rd", {27'd0, wb_rd}, 32'd8);
        check("alu wb_data", wb_data, 32'h1234_5678);
        check("alu retired before", retired_cnt, 32'd0);
        bubble();
        tick();
        check("alu retired after", retired_cnt, 32'd1);

        mem_data = 32'hAABB_CC80;
        drive(1, 1, 1, 5'd3, 32'h0000_1003, 2'b10, 0);
        tick();
        check("byte off3 signed", wb_data, SUBWORD ? 32'hFFFF_FF80 : 32'hAABB_CC80);
        drive(1, 1, 1, 5'd3, 32'h0000_1003, 2'b10, 1);
        tick();
        check("byte off3 unsigned", wb_data, SUBWORD ? 32'h0000_0080 : 32'hAABB_CC80);

        mem_data = 32'h8001_7FFF;
        drive(1, 1, 1, 5'd4, 32'h0000_2001, 2'b01, 0);
        tick();
        check("half off1 signed", wb_data, SUBWORD ? 32'hFFFF_8001 : 32'h8001_7FFF);
        drive(1, 1, 1, 5'd4, 32'h0000_2002, 2'b01, 0);
        tick();
        check("half off2 signed", wb_data, SUBWORD ? 32'h0000_7FFF : 32'h8001_7FFF);

        mem_data = 32'hAABB_CC80;
        drive(1, 1, 1, 5'd6, 32'h0000_4000, 2'b10, 1);
        tick();
        check("byte off0 unsigned", wb_data, SUBWORD ? 32'h0000_00AA : 32'hAABB_CC80);
        drive(1, 1, 1, 5'd6, 32'h0000_4003, 2'b11, 0);
        tick();
        check("size11 as word", wb_data, 32'hAABB_CC80);
        bubble();
        tick();
        check("retired after loads", retired_cnt, 32'd7);

        drive(1, 1, 0, 5'd5, 32'hA5A5_A5A5, 2'b00, 0);
        tick();
        stall = 1;
        drive(1, 1, 0, 5'd12, 32'h0BAD_0BAD, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall wb_en", {31'd0, wb_en}, 32'd1);
            check("stall wb_rd", {27'd0, wb_rd}, 32'd5);
            check("stall wb_data", wb_data, 32'hA5A5_A5A5);
            check("stall retired", retired_cnt, 32'd7);
        end
        flush = 1;
        tick();
        check("stall+flush wb_en", {31'd0, wb_en}, 32'd0);
        check("stall+flush retired", retired_cnt, 32'd7);
        stall = 0; flush = 0;
        bubble();
        tick();
        check("after flush retired", retired_cnt, 32'd7);

        drive(1, 1, 0, 5'd0, 32'h0000_0055, 2'b00, 0);
        tick();
        check("rd0 wb_en", {31'd0, wb_en}, 32'd0);
        bubble();
        tick();
        check("rd0 retired", retired_cnt, 32'd8);

        drive(1, 1, 0, 5'd9, 32'hCAFE_F00D, 2'b00, 0);
        tick();
        check("pre-reset wb_en", {31'd0, wb_en}, 32'd1);
        stall = 1; rst = 1;
        drive(1, 1, 0, 5'd10, 32'h1111_2222, 2'b00, 0);
        tick();
        check("stalled reset wb_en", {31'd0, wb_en}, 32'd0);
        check("stalled reset wb_rd", {27'd0, wb_rd}, 32'd0);
        check("stalled reset wb_data", wb_data, 32'd0);
        check("stalled reset retired", retired_cnt, 32'd0);
        rst = 0; stall = 0;
        bubble();
        tick();
        check("post-reset retired", retired_cnt, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter RA_W, default 5, register-file address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall  input  1  hold the stage register.
REQ-006 SHALL have port flush  input  1  invalidate the stage register.
REQ-007 SHALL have port in_valid  input  1  the EX/MEM instruction is valid.
REQ-008 SHALL have port in_reg_write  input  1  the instruction writes the register file.
REQ-009 SHALL have port in_mem_to_reg  input  1  the writeback source is memory, not the ALU.
REQ-010 SHALL have port in_rd  input  RA_W  destination register.
REQ-011 SHALL have port in_alu_result  input  DATA_W  ALU result or byte address.
REQ-012 SHALL have port in_ld_size  input  2  load size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-013 SHALL have port in_ld_unsigned  input  1  zero-extend instead of sign-extend.
REQ-014 SHALL have port mem_data  input  DATA_W  memory-unit read data, valid one cycle after address capture.
REQ-015 SHALL have port wb_en  output  1  register-file write enable.
REQ-016 SHALL have port wb_rd  output  RA_W  register-file write address.
REQ-017 SHALL have port wb_data  output  DATA_W  register-file write data.
REQ-018 SHALL have port retired_cnt  output  32  count of valid instructions leaving the stage.

Function
REQ-019 SHALL capture all in_* signals into the stage register on each edge where rst=0, stall=0 and flush=0.
REQ-020 SHALL hold the stage register unchanged on an edge with stall=1 and flush=0.
REQ-021 SHALL clear the valid bit on an edge with flush=1, regardless of stall; flush SHALL win over stall.
REQ-022 SHALL drive wb_en = valid AND reg_write AND (rd != 0), combinationally from the stage register.
REQ-023 SHALL drive wb_rd from the registered rd.
REQ-024 SHALL drive wb_data from the registered alu_result when mem_to_reg=0, and from extracted mem_data when mem_to_reg=1; mem_data SHALL be used combinationally (latency: address capture to wb_data is 1 cycle).
REQ-025 SHALL extract loads big-endian: byte offset alu_result[1:0]=0 selects bits 31:24, 3 selects bits 7:0.
REQ-026 SHALL select halfwords by alu_result[1] (0 selects 31:16, 1 selects 15:0) and ignore alu_result[0].
REQ-027 SHALL ignore alu_result[1:0] for word loads.
REQ-028 SHALL sign-extend byte and half results to DATA_W unless ld_unsigned=1, in which case it SHALL zero-extend them.
REQ-029 SHALL increment retired_cnt by 1 on each edge where valid=1, stall=0 and rst=0 (flush=1 still counts the departing instruction), wrapping from 0xFFFFFFFF to 0.

Reset
REQ-030 SHALL on rst=1 clear valid, reg_write, mem_to_reg, rd, alu_result, ld_size, ld_unsigned and retired_cnt to 0, giving wb_en=0, wb_rd=0, wb_data=0.
REQ-031 SHALL give rst priority over stall and flush; an instruction held by stall when rst asserts SHALL be discarded and not counted.

Configuration
REQ-032 SHALL support macro MEM_WB_SUBWORD_EN: when defined, REQ-025 to REQ-028 apply.
REQ-033 SHALL, when MEM_WB_SUBWORD_EN is undefined, not register ld_size or ld_unsigned and SHALL treat every load as a word load (wb_data=mem_data).

Structure
REQ-034 SHALL take the load-size encoding enum (LD_WORD, LD_HALF, LD_BYTE) and DATA_W/RA_W defaults from a shared package, mips_pkg.
REQ-035 SHALL place load extraction in one combinational sub-module, load_align (inputs mem_data, offset, size, unsigned; output extended data).

Verification
REQ-036 SHALL cover: ALU op, in_alu_result=0x1234_5678, rd=8, reg_write=1, mem_to_reg=0 -> next cycle wb_en=1, wb_rd=8, wb_data=0x1234_5678, retired_cnt increments.
REQ-037 SHALL cover: byte load, offset 3, mem_data=0xAABBCC80, signed -> wb_data=0xFFFFFF80; same stimulus with ld_unsigned=1 -> 0x00000080.
REQ-038 SHALL cover: half load, offset 1, mem_data=0x8001_7FFF, signed -> wb_data=0xFFFF8001 (bit0 ignored); offset 2 -> 0x00007FFF.
REQ-039 SHALL cover: stall=1 for 3 cycles with a new instruction on the inputs -> wb outputs hold the old instruction, retired_cnt unchanged; then stall=1 and flush=1 together -> wb_en=0 next cycle.
REQ-040 SHALL cover: rd=0, reg_write=1 -> wb_en=0 while retired_cnt still increments.
REQ-041 SHALL cover: rst=1 while the stage is stalled with a valid instruction -> next cycle all outputs are 0; with MEM_WB_SUBWORD_EN undefined, a byte load returns the full mem_data.
